// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, response codes and the default-slave FSM state types.
`default_nettype none

package axi_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_default_slave.sv
// axi_default_slave: decode-error slave that completes every routed burst with an error response.
// Rev 1.0 - independent write and read FSMs, all outputs registered.
`default_nettype none

module axi_default_slave
    import axi_pkg::*;
#(
    parameter logic [1:0]               ERR_RESP  = RESP_DECERR,
    parameter logic [AXI_DATA_BITS-1:0] FILL_DATA = 32'h0000_0000
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    // write address
    input  logic [AXI_IDS_BITS-1:0]  S_AWID,
    input  logic [AXI_ADDR_BITS-1:0] S_AWAddr,
    input  logic [AXI_LEN_BITS-1:0]  S_AWLen,
    input  logic [AXI_SIZE_BITS-1:0] S_AWSize,
    input  logic [1:0]               S_AWBurst,
    input  logic                     S_AWValid,
    output logic                     S_AWReady,
    // write data
    input  logic [AXI_DATA_BITS-1:0] S_WData,
    input  logic [AXI_STRB_BITS-1:0] S_WStrb,
    input  logic                     S_WLast,
    input  logic                     S_WValid,
    output logic                     S_WReady,
    // write response
    output logic [AXI_IDS_BITS-1:0]  S_BID,
    output logic [1:0]               S_BResp,
    output logic                     S_BValid,
    input  logic                     S_BReady,
    // read address
    input  logic [AXI_IDS_BITS-1:0]  S_ARID,
    input  logic [AXI_ADDR_BITS-1:0] S_ARAddr,
    input  logic [AXI_LEN_BITS-1:0]  S_ARLen,
    input  logic [AXI_SIZE_BITS-1:0] S_ARSize,
    input  logic [1:0]               S_ARBurst,
    input  logic                     S_ARValid,
    output logic                     S_ARReady,
    // read data
    output logic [AXI_IDS_BITS-1:0]  S_RID,
    output logic [AXI_DATA_BITS-1:0] S_RData,
    output logic [1:0]               S_RResp,
    output logic                     S_RLast,
    output logic                     S_RValid,
    input  logic                     S_RReady
);

    w_state_t                  r_wstate;
    logic                      r_awready;
    logic                      r_wready;
    logic                      r_bvalid;
    logic [AXI_IDS_BITS-1:0]   r_bid;
    logic [1:0]                r_bresp;
    logic [AXI_LEN_BITS-1:0]   r_wlen;
    logic [AXI_LEN_BITS-1:0]   r_wcnt;

    r_state_t                  r_rstate;
    logic                      r_arready;
    logic                      r_rvalid;
    logic                      r_rlast;
    logic [AXI_IDS_BITS-1:0]   r_rid;
    logic [1:0]                r_rresp;
    logic [AXI_LEN_BITS-1:0]   r_rlen;
    logic [AXI_LEN_BITS-1:0]   r_rcnt;

    // Address, size, burst, write payload and the write beat count carry no behaviour here.
    logic w_unused;
    assign w_unused = &{1'b0, S_AWAddr, S_AWSize, S_AWBurst, S_WData, S_WStrb,
                        S_ARAddr, S_ARSize, S_ARBurst, r_wlen, r_wcnt};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (S_AWValid) begin
                        r_bid     <= S_AWID;
                        r_wlen    <= S_AWLen;
                        r_wcnt    <= '0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_WValid) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        // WLAST alone closes the burst, even if the count disagrees with AWLen.
                        if (S_WLast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= ERR_RESP;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_BReady) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= '0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_bresp   <= '0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (S_ARValid) begin
                        r_rid     <= S_ARID;
                        r_rlen    <= S_ARLen;
                        r_rcnt    <= '0;
                        r_rlast   <= (S_ARLen == '0);
                        r_rresp   <= ERR_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_RReady) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= '0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            // Last flag tracks the advanced count, so len=max never wraps early.
                            r_rcnt  <= r_rcnt + 1'b1;
                            r_rlast <= ((r_rcnt + 1'b1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                    r_rresp   <= '0;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AWReady = r_awready;
    assign S_WReady  = r_wready;
    assign S_BValid  = r_bvalid;
    assign S_BID     = r_bid;
    assign S_BResp   = r_bresp;

    assign S_ARReady = r_arready;
    assign S_RValid  = r_rvalid;
    assign S_RLast   = r_rlast;
    assign S_RID     = r_rid;
    assign S_RResp   = r_rresp;
    assign S_RData   = FILL_DATA;

endmodule

`default_nettype wire
